aes_block_stager: RTL and testbench

AES_BLOCK_STAGER -- requirements
Module: aes_block_stager

---
 rtl/aes_block_stager.sv | 146 ++++++++++++++
 tb/tb_aes_block_stager.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_stager.sv
// Batches plaintext blocks behind a loaded AES key, feeds them to an external AES
// pipeline in order and buffers the returned results for a downstream consumer.
module aes_block_stager #(
  parameter int BLOCK_W   = 128,
  parameter int DEPTH     = 4,
  parameter int KEY_WORDS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          key_reload,
  input  logic [BLOCK_W-1:0]            in_data,
  input  logic                          in_valid,
  output logic                          ready_for_inp,
  output logic [BLOCK_W-1:0]            out_data,
  output logic                          out_valid,
  input  logic                          ready_to_out,
  output logic [KEY_WORDS*BLOCK_W-1:0]  key_out,
  output logic                          key_valid,
  output logic [BLOCK_W-1:0]            core_in_data,
  output logic                          core_in_valid,
  input  logic                          core_in_ready,
  input  logic [BLOCK_W-1:0]            core_out_data,
  input  logic                          core_out_valid,
  output logic [$clog2(DEPTH+1)-1:0]    blk_count,
  output logic                          err
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int KCW  = $clog2(KEY_WORDS + 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_WORDS - 1);

  typedef enum logic [1:0] {KEY, LOAD, RUN} state_t;

  state_t               state;
  logic [KCW-1:0]       key_cnt;
  logic [CW-1:0]        iss_cnt;
  logic [CW-1:0]        ret_cnt;
  logic [CW-1:0]        occ;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [BLOCK_W-1:0]   blocks [DEPTH];
  logic [BLOCK_W-1:0]   fifo   [DEPTH];

  logic in_xfer;
  logic core_xfer;
  logic capture;
  logic pop;
  logic batch_done;

  // Handshake qualifiers; none of the outputs depend combinationally on inputs.
  assign ready_for_inp = (state == KEY) || ((state == LOAD) && (blk_count < DEPTH_C));
  assign in_xfer       = in_valid && ready_for_inp;
  assign core_in_valid = (state == RUN) && (iss_cnt < blk_count);
  assign core_xfer     = core_in_valid && core_in_ready;
  assign core_in_data  = core_in_valid ? blocks[iss_cnt[PW-1:0]] : '0;
  assign out_valid     = (occ != '0);
  assign out_data      = out_valid ? fifo[rd_ptr] : '0;
  assign pop           = out_valid && ready_to_out;
  assign capture       = core_out_valid && (ret_cnt < iss_cnt);
  assign batch_done    = (state == RUN) && (iss_cnt == blk_count) &&
                         (ret_cnt == blk_count) && (occ == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= KEY;
      key_cnt   <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      blk_count <= '0;
      iss_cnt   <= '0;
      ret_cnt   <= '0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      // A result with nothing outstanding is dropped and flagged for good.
      if (capture) begin
        ret_cnt <= ret_cnt + 1'b1;
        wr_ptr  <= wr_ptr + 1'b1;
      end else if (core_out_valid) begin
        err <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      case (state)
        KEY: begin
          if (key_reload) begin
            key_cnt <= '0;
          end else if (in_xfer) begin
            for (int k = 0; k < KEY_WORDS; k++)
              if (key_cnt == KCW'(k))
                key_out[(KEY_WORDS-1-k)*BLOCK_W +: BLOCK_W] <= in_data;
            if (key_cnt == KEY_LAST) begin
              key_cnt   <= '0;
              key_valid <= 1'b1;
              state     <= LOAD;
            end else begin
              key_cnt <= key_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (key_reload) begin
            state     <= KEY;
            key_valid <= 1'b0;
            key_out   <= '0;
            key_cnt   <= '0;
            blk_count <= '0;
          end else begin
            if (in_xfer) blk_count <= blk_count + 1'b1;
            if (start && ((blk_count != '0) || in_xfer)) state <= RUN;
          end
        end
        RUN: begin
          if (batch_done) begin
            state     <= LOAD;
            blk_count <= '0;
            iss_cnt   <= '0;
            ret_cnt   <= '0;
          end else if (core_xfer) begin
            iss_cnt <= iss_cnt + 1'b1;
          end
        end
        default: state <= KEY;
      endcase
    end
  end

  // Data storage carries no reset; every read path is gated by a valid.
  always_ff @(posedge clock) begin
    if ((state == LOAD) && !key_reload && in_xfer)
      blocks[blk_count[PW-1:0]] <= in_data;
    if (capture)
      fifo[wr_ptr] <= core_out_data;
  end

endmodule

// File: tb/tb_aes_block_stager.sv
// Directed bench for aes_block_stager: a queue-based transaction model predicts every
// output each cycle, plus literal checks pinning reset values, keys and boundaries.
module tb_aes_block_stager;

  localparam int BW    = 128;
  localparam int DEPTH = 4;
  localparam int KW    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [127:0] K0   = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [127:0] K2A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2B  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] B0   = 128'hd9313225f88406e5a55909c5aff5269a;
  localparam logic [127:0] B1   = 128'h86a7a9531534f7da2e4c303d8a318a72;
  localparam logic [127:0] B2   = 128'h1c3c0c95956809532fcf0e2449a6b525;
  localparam logic [127:0] B3   = 128'hb16aedf5aa0de657ba637b391aafd255;
  localparam logic [127:0] MASK = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;

  logic              clock, reset, start, key_reload, in_valid, ready_for_inp;
  logic [BW-1:0]     in_data, out_data, core_in_data, core_out_data;
  logic              out_valid, ready_to_out, key_valid, core_in_valid;
  logic              core_in_ready, core_out_valid, err;
  logic [KW*BW-1:0]  key_out;
  logic [CW-1:0]     blk_count;

  aes_block_stager #(.BLOCK_W(BW), .DEPTH(DEPTH), .KEY_WORDS(KW)) dut (
    .clock(clock), .reset(reset), .start(start), .key_reload(key_reload),
    .in_data(in_data), .in_valid(in_valid), .ready_for_inp(ready_for_inp),
    .out_data(out_data), .out_valid(out_valid), .ready_to_out(ready_to_out),
    .key_out(key_out), .key_valid(key_valid),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid),
    .core_in_ready(core_in_ready), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .blk_count(blk_count), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // Transaction-level model: a key word list, a batch queue, an issue index,
  // a return count and a result queue.
  typedef enum {M_KEY, M_LOAD, M_RUN} mode_t;
  mode_t         m_mode;
  logic [127:0]  m_key [KW];
  int            m_kcnt, m_iss, m_ret;
  logic          m_kv, m_err;
  logic [127:0]  m_blocks [$];
  logic [127:0]  m_outq [$];

  always @(posedge clock or negedge reset) begin : model
    bit rdy, civ, ov, inx, cx, pop, cap, done;
    if (!reset) begin
      m_mode = M_KEY; m_kcnt = 0; m_kv = 0; m_iss = 0; m_ret = 0; m_err = 0;
      m_blocks.delete(); m_outq.delete();
    end else begin
      rdy  = (m_mode == M_KEY) || (m_mode == M_LOAD && m_blocks.size() < DEPTH);
      civ  = (m_mode == M_RUN) && (m_iss < m_blocks.size());
      ov   = m_outq.size() > 0;
      inx  = in_valid && rdy;
      cx   = civ && core_in_ready;
      pop  = ov && ready_to_out;
      cap  = core_out_valid && (m_ret < m_iss);
      done = (m_mode == M_RUN) && (m_iss == m_blocks.size()) &&
             (m_ret == m_blocks.size()) && !ov;
      if (core_out_valid && !cap) m_err = 1;
      if (pop) void'(m_outq.pop_front());
      if (cap) begin m_outq.push_back(core_out_data); m_ret++; end
      case (m_mode)
        M_KEY: begin
          if (key_reload) m_kcnt = 0;
          else if (inx) begin
            m_key[m_kcnt] = in_data;
            m_kcnt++;
            if (m_kcnt == KW) begin m_kcnt = 0; m_kv = 1; m_mode = M_LOAD; end
          end
        end
        M_LOAD: begin
          if (key_reload) begin
            m_mode = M_KEY; m_kv = 0; m_kcnt = 0; m_blocks.delete();
          end else begin
            if (inx) m_blocks.push_back(in_data);
            if (start && m_blocks.size() > 0) begin m_mode = M_RUN; m_iss = 0; m_ret = 0; end
          end
        end
        default: begin
          if (done) begin m_mode = M_LOAD; m_blocks.delete(); m_iss = 0; m_ret = 0; end
          else if (cx) m_iss++;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_output();
    logic rdy, civ, ov;
    if (!reset) return;
    rdy = (m_mode == M_KEY) || (m_mode == M_LOAD && m_blocks.size() < DEPTH);
    civ = (m_mode == M_RUN) && (m_iss < m_blocks.size());
    ov  = m_outq.size() > 0;
    check("ready_for_inp", ready_for_inp, rdy);
    check("key_valid", key_valid, m_kv);
    if (m_kv) check("key_out", key_out, {m_key[0], m_key[1]});
    check("blk_count", blk_count, m_blocks.size());
    check("core_in_valid", core_in_valid, civ);
    if (civ) check("core_in_data", core_in_data, m_blocks[m_iss]);
    check("out_valid", out_valid, ov);
    if (ov) check("out_data", out_data, m_outq[0]);
    check("err", err, m_err);
  endtask

  // Stand-in AES core: returns each issued block XOR MASK one cycle later.
  logic [127:0] pend [$];
  logic cir_next, rto_next, force_ret;

  task automatic apply_stimulus(input logic iv, input logic [127:0] d,
                                input logic st, input logic kr);
    @(negedge clock);
    check_output();
    core_out_valid = 1'b0;
    core_out_data  = '0;
    if (force_ret) begin
      core_out_valid = 1'b1;
      core_out_data  = 128'hdead;
    end else if (pend.size() > 0) begin
      core_out_valid = 1'b1;
      core_out_data  = pend.pop_front() ^ MASK;
    end
    in_valid = iv; in_data = d; start = st; key_reload = kr;
    core_in_ready = cir_next;
    ready_to_out  = rto_next;
    if (reset && core_in_valid && core_in_ready) pend.push_back(core_in_data);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_load(input int budget);
    int n = 0;
    while (m_mode != M_LOAD && n < budget) begin
      idle(1);
      n++;
    end
    if (m_mode != M_LOAD) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL batch_done: still running after %0d cycles, required return to LOAD", budget);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: bench did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0; start = 0; key_reload = 0; in_valid = 0; in_data = '0;
    core_out_valid = 0; core_out_data = '0; core_in_ready = 1; ready_to_out = 1;
    cir_next = 1; rto_next = 1; force_ret = 0;
    #12;
    check("rst_ready", ready_for_inp, 1'b1);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_out", key_out, '0);
    check("rst_blk_count", blk_count, '0);
    check("rst_core_in_valid", core_in_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Key load, then a full batch under stall and output backpressure
    apply_stimulus(1, K0, 0, 0);
    apply_stimulus(1, K0, 0, 0);
    idle(1);
    check("key_valid_lit", key_valid, 1'b1);
    check("key_out_lit", key_out, {K0, K0});
    apply_stimulus(1, B0, 0, 0);
    apply_stimulus(1, B1, 0, 0);
    apply_stimulus(1, B2, 0, 0);
    apply_stimulus(1, B3, 0, 0);
    apply_stimulus(1, 128'hbad, 0, 0);
    idle(1);
    check("full_blk_count", blk_count, 3'd4);
    check("full_ready", ready_for_inp, 1'b0);
    cir_next = 0; rto_next = 0;
    apply_stimulus(0, '0, 1, 0);
    repeat (5) begin
      idle(1);
      check("stall_core_in_data", core_in_data, B0);
    end
    cir_next = 1;
    idle(12);
    check("held_out_valid", out_valid, 1'b1);
    check("held_blk_count", blk_count, 3'd4);
    check("held_core_in_valid", core_in_valid, 1'b0);
    check("held_out_data", out_data, B0 ^ MASK);
    rto_next = 1;
    wait_load(20);
    idle(1);
    check("after_batch_blk_count", blk_count, '0);
    check("after_batch_key_valid", key_valid, 1'b1);

    // Start with no blocks is ignored; start with the first block is a batch of 1
    apply_stimulus(0, '0, 1, 0);
    idle(1);
    check("empty_start_civ", core_in_valid, 1'b0);
    check("empty_start_ready", ready_for_inp, 1'b1);
    apply_stimulus(1, B2, 1, 0);
    idle(1);
    check("batch1_core_in_data", core_in_data, B2);
    check("batch1_blk_count", blk_count, 3'd1);
    wait_load(20);
    idle(1);

    // Key reload after two blocks, then an unexpected core result
    apply_stimulus(1, B0, 0, 0);
    apply_stimulus(1, B1, 0, 0);
    apply_stimulus(0, '0, 0, 1);
    idle(1);
    check("reload_blk_count", blk_count, '0);
    check("reload_key_valid", key_valid, 1'b0);
    apply_stimulus(1, K2A, 0, 0);
    apply_stimulus(1, K2B, 0, 0);
    idle(1);
    check("reload_key_out", key_out, {K2A, K2B});
    force_ret = 1;
    idle(1);
    force_ret = 0;
    idle(1);
    check("err_sticky", err, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of a stalled batch
    apply_stimulus(1, B1, 0, 0);
    apply_stimulus(1, B3, 0, 0);
    cir_next = 0;
    apply_stimulus(0, '0, 1, 0);
    idle(2);
    check("pre_reset_civ", core_in_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ready", ready_for_inp, 1'b1);
    check("mid_rst_civ", core_in_valid, 1'b0);
    check("mid_rst_core_data", core_in_data, '0);
    check("mid_rst_blk_count", blk_count, '0);
    check("mid_rst_key_valid", key_valid, 1'b0);
    check("mid_rst_key_out", key_out, '0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_err", err, 1'b0);
    pend.delete();
    cir_next = 1;
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    check("post_rst_key_valid", key_valid, 1'b0);
    check("post_rst_ready", ready_for_inp, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
